// File: rtl/microcpu_pkg.sv
// Shared types and constants for the micro-CPU execute stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: datapath/register-index widths, opcode and FSM state encodings,
// and the single-cycle ALU function used by exec_unit.
package microcpu_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 4;

  // Last iteration index of the 16-step MUL/DIVU sequence.
  localparam logic [CNT_W-1:0] ITER_LAST = 4'd15;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_MUL  = 3'd6,
    OP_DIVU = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_multi(input op_e op);
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

  // Returns {carry, result}. Bit DATA_W is the ADD carry-out or SUB borrow,
  // and is forced to 0 for every other op.
  function automatic logic [DATA_W:0] alu_calc(input op_e op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_SHL:  r = {1'b0, a << b[3:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Operation request / completion bundle between issue logic and exec_unit.
// Latency: n/a (wires only).
// Backpressure: none; requests presented while busy are simply dropped.
//
// master: drives start/op/src_a/src_b/dest_in, observes status and result.
// slave : exec_unit side.
interface exec_unit_if;
  import microcpu_pkg::*;

  logic                  start;
  logic [2:0]            op;
  logic [DATA_W-1:0]     src_a;
  logic [DATA_W-1:0]     src_b;
  logic [REG_ADDR_W-1:0] dest_in;

  logic                  busy;
  logic                  done;
  logic                  wr_en;
  logic [DATA_W-1:0]     result;
  logic [REG_ADDR_W-1:0] dest_out;
  logic                  zero;
  logic                  carry;

  modport master (
    output start, op, src_a, src_b, dest_in,
    input  busy, done, wr_en, result, dest_out, zero, carry
  );

  modport slave (
    input  start, op, src_a, src_b, dest_in,
    output busy, done, wr_en, result, dest_out, zero, carry
  );

endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply (shift-add) / unsigned divide (restoring), one bit per step.
// Latency: 16 steps after load; result port shows the post-step value combinationally.
// Backpressure: none; caller sequences load/step.
//
// Ports: clk, rst_n (sync, active-low), load (capture a/b/is_div), step
// (perform one iteration), is_div (0=MUL, 1=DIVU), a, b operands,
// result = value the result register will hold after this edge.
module mdu_iter
  import microcpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  // MUL : acc = partial product, x = multiplicand (<<), y = multiplier (>>)
  // DIVU: acc = remainder,       x = dividend shifting out / quotient in, y = divisor
  logic              div_mode;
  logic [DATA_W-1:0] acc, x, y;
  logic [DATA_W-1:0] acc_nxt, x_nxt, y_nxt;
  logic [DATA_W:0]   rem_sh, diff;
  logic              ge;

  always_comb begin
    rem_sh  = {acc, x[DATA_W-1]};
    diff    = rem_sh - {1'b0, y};
    ge      = ~diff[DATA_W];
    acc_nxt = acc;
    x_nxt   = x;
    y_nxt   = y;
    if (div_mode) begin
      // Divisor 0 never borrows, so every quotient bit is 1 -> 0xFFFF.
      acc_nxt = ge ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
      x_nxt   = {x[DATA_W-2:0], ge};
    end else begin
      acc_nxt = y[0] ? (acc + x) : acc;
      x_nxt   = x << 1;
      y_nxt   = y >> 1;
    end
  end

  // Forward the post-step value so the final step and the output capture
  // can share the same edge.
  always_comb begin
    result = div_mode ? x : acc;
    if (step) result = div_mode ? x_nxt : acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_mode <= 1'b0;
      acc      <= '0;
      x        <= '0;
      y        <= '0;
    end else if (load) begin
      div_mode <= is_div;
      acc      <= '0;
      x        <= a;
      y        <= b;
    end else if (step) begin
      acc <= acc_nxt;
      x   <= x_nxt;
      y   <= y_nxt;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus iterative MUL/DIVU via mdu_iter.
// Latency: 1 cycle for ADD..SHL, done 16 cycles after acceptance for MUL/DIVU.
// Backpressure: start accepted only in IDLE/DONE; ignored while busy (no queueing).
//
// Ports: clk, rst_n (sync, active-low), bus (exec_unit_if.slave):
// start/op/src_a/src_b/dest_in in; busy, done, wr_en (=done), result,
// dest_out, zero, carry out. Outputs hold until the next done.
module exec_unit
  import microcpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  exec_unit_if.slave  bus
);

  state_e                state, state_nxt;
  logic [CNT_W-1:0]      count, count_nxt;
  logic                  accept, mdu_load, mdu_step, finish;
  op_e                   op_in;
  logic [DATA_W:0]       alu_res;
  logic [DATA_W-1:0]     mdu_res;

  logic [REG_ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0]     result_q;
  logic [REG_ADDR_W-1:0] dest_out_q;
  logic                  zero_q, carry_q;

  assign op_in   = op_e'(bus.op);
  assign alu_res = alu_calc(op_in, bus.src_a, bus.src_b);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    accept    = 1'b0;
    mdu_load  = 1'b0;
    mdu_step  = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (bus.start) begin
          accept = 1'b1;
          if (is_multi(op_in)) begin
            mdu_load  = 1'b1;
            count_nxt = '0;
            state_nxt = ST_EXEC;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_EXEC: begin
        mdu_step  = 1'b1;
        count_nxt = count + 1'b1;
        if (count == ITER_LAST) begin
          finish    = 1'b1;
          count_nxt = '0;
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      count      <= '0;
      dest_q     <= '0;
      result_q   <= '0;
      dest_out_q <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (mdu_load) dest_q <= bus.dest_in;
      // Single-cycle ops commit straight from the inputs on the accepting edge;
      // iterative ops leave the previous outputs untouched until they finish.
      if (accept && !mdu_load) begin
        result_q   <= alu_res[DATA_W-1:0];
        carry_q    <= alu_res[DATA_W];
        zero_q     <= (alu_res[DATA_W-1:0] == '0);
        dest_out_q <= bus.dest_in;
      end
      if (finish) begin
        result_q   <= mdu_res;
        carry_q    <= 1'b0;
        zero_q     <= (mdu_res == '0);
        dest_out_q <= dest_q;
      end
    end
  end

  mdu_iter u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (mdu_load),
    .step   (mdu_step),
    .is_div (op_in == OP_DIVU),
    .a      (bus.src_a),
    .b      (bus.src_b),
    .result (mdu_res)
  );

  assign bus.busy     = (state == ST_EXEC);
  assign bus.done     = (state == ST_DONE);
  assign bus.wr_en    = (state == ST_DONE);
  assign bus.result   = result_q;
  assign bus.dest_out = dest_out_q;
  assign bus.zero     = zero_q;
  assign bus.carry    = carry_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: scoreboard queue + negedge monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_exec_unit;
  import microcpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  exec_unit_if bus ();

  exec_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  dest;
    logic        zero;
    logic        carry;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_e op, input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] d);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.src_a   = a;
    bus.src_b   = b;
    bus.dest_in = d;
  endtask

  // Garbage on the operand inputs after acceptance proves they were captured.
  task automatic scramble();
    bus.start   = 1'b0;
    bus.op      = OP_SUB;
    bus.src_a   = 16'hDEAD;
    bus.src_b   = 16'hBEEF;
    bus.dest_in = 5'd31;
  endtask

  task automatic push(input logic [15:0] r, input logic [4:0] d, input logic z,
                      input logic c);
    exp_t e;
    e.res   = r;
    e.dest  = d;
    e.zero  = z;
    e.carry = c;
    sb.push_back(e);
  endtask

  // Issues one op, then measures edges from acceptance to done and busy cycles.
  // With poke set, a start is pulsed mid-flight and must be ignored.
  task automatic run_op(input string name, input op_e op, input logic [15:0] a,
                        input logic [15:0] b, input logic [4:0] d,
                        input logic [15:0] exp_r, input logic exp_z, input logic exp_c,
                        input int exp_lat, input bit poke);
    int lat;
    int busy_n;
    lat    = 0;
    busy_n = 0;
    push(exp_r, d, exp_z, exp_c);
    drive(op, a, b, d);
    tick();
    scramble();
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_n++;
      bus.start = (poke && lat == 3);
      tick();
      lat++;
    end
    bus.start = 1'b0;
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " busy_cycles"}, busy_n, exp_lat);
  endtask

  // Monitor: pops one expectation per done cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.done === 1'b1) begin
        chk("wr_en with done", bus.wr_en, 1);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: result 0x%0h dest %0d, none expected",
                   bus.result, bus.dest_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", bus.result, e.res);
          chk("dest_out", bus.dest_out, e.dest);
          chk("zero", bus.zero, e.zero);
          chk("carry", bus.carry, e.carry);
        end
      end else begin
        chk("wr_en idle", bus.wr_en, 0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = '0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.dest_in = '0;
    repeat (3) tick();
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset result", bus.result, 0);
    rst_n = 1'b1;
    tick();

    run_op("ADD ffff+1", OP_ADD, 16'hFFFF, 16'h0001, 5'd1, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
    run_op("SUB 3-5",    OP_SUB, 16'h0003, 16'h0005, 5'd2, 16'hFFFE, 1'b0, 1'b1, 0, 1'b0);
    run_op("SHL 1<<4",   OP_SHL, 16'h0001, 16'h00F4, 5'd3, 16'h0010, 1'b0, 1'b0, 0, 1'b0);
    // Outputs must hold between dones.
    repeat (3) tick();
    chk("hold done", bus.done, 0);
    chk("hold result", bus.result, 16'h0010);
    chk("hold dest_out", bus.dest_out, 5'd3);

    run_op("XOR",        OP_XOR, 16'hA5A5, 16'h5A5A, 5'd5, 16'hFFFF, 1'b0, 1'b0, 0, 1'b0);
    run_op("SUB 5-5",    OP_SUB, 16'h0005, 16'h0005, 5'd9, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    run_op("MUL",        OP_MUL, 16'h0123, 16'h0010, 5'd4, 16'h1230, 1'b0, 1'b0, 16, 1'b1);
    run_op("DIVU 100/7", OP_DIVU, 16'd100, 16'd7, 5'd6, 16'h000E, 1'b0, 1'b0, 16, 1'b0);
    run_op("DIVU x/0",   OP_DIVU, 16'h1234, 16'h0000, 5'd7, 16'hFFFF, 1'b0, 1'b0, 16, 1'b0);

    // Reset in the middle of a MUL: abort, clear outputs, no done.
    drive(OP_MUL, 16'h0123, 16'h0010, 5'd12);
    tick();
    scramble();
    repeat (8) tick();
    chk("mid-MUL busy", bus.busy, 1);
    rst_n = 1'b0;
    tick();
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    chk("abort wr_en", bus.wr_en, 0);
    chk("abort result", bus.result, 0);
    chk("abort dest_out", bus.dest_out, 0);
    chk("abort zero", bus.zero, 0);
    chk("abort carry", bus.carry, 0);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("post-abort done", bus.done, 0);

    // Reset wins over a simultaneous start.
    drive(OP_ADD, 16'h0002, 16'h0003, 5'd13);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    scramble();
    chk("rst+start done", bus.done, 0);
    chk("rst+start busy", bus.busy, 0);
    tick();
    chk("rst+start done later", bus.done, 0);

    run_op("ADD 2+3", OP_ADD, 16'h0002, 16'h0003, 5'd8, 16'h0005, 1'b0, 1'b0, 0, 1'b0);

    // Back-to-back: start held across two single-cycle ops.
    push(16'h000F, 5'd10, 1'b0, 1'b0);
    push(16'hF00F, 5'd11, 1'b0, 1'b0);
    drive(OP_AND, 16'h00FF, 16'h0F0F, 5'd10);
    tick();
    chk("b2b first done", bus.done, 1);
    drive(OP_OR, 16'hF000, 16'h000F, 5'd11);
    tick();
    chk("b2b second done", bus.done, 1);
    scramble();
    tick();
    chk("b2b return idle", bus.done, 0);

    repeat (3) tick();
    chk("scoreboard drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
